exmem_latch: RTL and testbench

//  EX/MEM pipeline register of the 5-stage MIPS pipeline. Captures EX results, drives the

---
 rtl/exmem_latch_pkg.sv | 34 +++
 rtl/exmem_latch_dmem_fsm.sv | 51 +++++
 rtl/exmem_latch.sv | 94 +++++++++
 tb/tb_exmem_latch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/exmem_latch_pkg.sv
// Shared types for the EX/MEM pipeline register: word/register widths,
// the latched-field bundle and the data-memory handshake states.
package exmem_latch_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } exmem_state_t;

    typedef struct packed {
        logic     valid;
        logic     regWrite;
        logic     memRead;
        logic     memWrite;
        logic     memtoReg;
        logic     halt;
        regbits_t wsel;
        word_t    aluout;
        word_t    storeData;
        word_t    npc;
    } exmem_t;

    function automatic logic isMemOp(input exmem_t e);
        return e.valid & (e.memRead | e.memWrite);
    endfunction

endpackage

// File: rtl/exmem_latch_dmem_fsm.sv
// Data-memory handshake for the MEM stage: holds the request until dhit,
// captures load data and freezes upstream stages while a request is open.
module exmem_latch_dmem_fsm
    import exmem_latch_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  advance,
    input  logic  loadMemOp,
    input  logic  dhit,
    input  logic  memRead,
    input  logic  memWrite,
    input  word_t dmemload,
    output logic  dmemREN,
    output logic  dmemWEN,
    output logic  stall,
    output word_t ldata
);

    exmem_state_t state;

    // A store that also claims to read is treated purely as a store, so load
    // data is captured only for read-only accesses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            ldata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (advance && loadMemOp) state <= ACCESS;
                end
                ACCESS: begin
                    if (dhit) begin
                        state <= DONE;
                        if (memRead && !memWrite) ldata <= dmemload;
                    end
                end
                DONE: begin
                    if (advance) state <= loadMemOp ? ACCESS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall   = (state == ACCESS);
    assign dmemREN = stall & memRead & ~memWrite;
    assign dmemWEN = stall & memWrite;

endmodule

// File: rtl/exmem_latch.sv
// EX/MEM pipeline register: latches EX results on advance, drives the data
// memory request and stalls the front of the pipeline until dhit.
module exmem_latch
    import exmem_latch_pkg::*;
#(
    parameter int DW = WORD_W,
    parameter int RW = REG_W
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          ihit,
    input  logic          dhit,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic          ex_RegWrite,
    input  logic          ex_MemRead,
    input  logic          ex_MemWrite,
    input  logic          ex_MemtoReg,
    input  logic          ex_halt,
    input  logic [RW-1:0] ex_wsel,
    input  logic [DW-1:0] ex_aluout,
    input  logic [DW-1:0] ex_storedata,
    input  logic [DW-1:0] ex_npc,
    input  logic [DW-1:0] dmemload,
    output logic          exmem_valid,
    output logic          exmem_RegWrite_out,
    output logic [RW-1:0] exmem_wsel_out,
    output logic          exmem_MemtoReg_out,
    output logic          exmem_halt_out,
    output logic [DW-1:0] exmem_aluout,
    output logic [DW-1:0] exmem_ldata,
    output logic [DW-1:0] exmem_npc,
    output logic          dmemREN,
    output logic          dmemWEN,
    output logic [DW-1:0] dmemaddr,
    output logic [DW-1:0] dmemstore,
    output logic          exmem_stall
);

    exmem_t entry;
    exmem_t nextEntry;
    logic   advance;

    assign advance = ihit & ~exmem_stall;

    // Flush or an empty EX slot loads an all-zero bubble.
    always_comb begin
        nextEntry = '0;
        if (ex_valid && !flush) begin
            nextEntry.valid     = 1'b1;
            nextEntry.regWrite  = ex_RegWrite;
            nextEntry.memRead   = ex_MemRead;
            nextEntry.memWrite  = ex_MemWrite;
            nextEntry.memtoReg  = ex_MemtoReg;
            nextEntry.halt      = ex_halt;
            nextEntry.wsel      = ex_wsel;
            nextEntry.aluout    = ex_aluout;
            nextEntry.storeData = ex_storedata;
            nextEntry.npc       = ex_npc;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) entry <= '0;
        else if (advance) entry <= nextEntry;
    end

    exmem_latch_dmem_fsm uFsm (
        .CLK      (CLK),
        .nRST     (nRST),
        .advance  (advance),
        .loadMemOp(isMemOp(nextEntry)),
        .dhit     (dhit),
        .memRead  (entry.memRead),
        .memWrite (entry.memWrite),
        .dmemload (dmemload),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .stall    (exmem_stall),
        .ldata    (exmem_ldata)
    );

    // Register 0 is hardwired, so a write to it must not look like a forward source.
    assign exmem_valid        = entry.valid;
    assign exmem_RegWrite_out = entry.valid & entry.regWrite & (entry.wsel != '0);
    assign exmem_wsel_out     = exmem_RegWrite_out ? entry.wsel : '0;
    assign exmem_MemtoReg_out = entry.memtoReg;
    assign exmem_halt_out     = entry.valid & entry.halt;
    assign exmem_aluout       = entry.aluout;
    assign exmem_npc          = entry.npc;
    assign dmemaddr           = entry.aluout;
    assign dmemstore          = entry.storeData;

endmodule

// File: tb/tb_exmem_latch.sv
// Bench for exmem_latch: directed vector table, async reset mid-access,
// then random traffic against a pending-request reference model.
module tb_exmem_latch;

    logic        clk, nRst;
    logic        ihit, dhit, flush, exValid, exRegWrite, exMemRead, exMemWrite, exMemtoReg, exHalt;
    logic [4:0]  exWsel;
    logic [31:0] exAluout, exStoredata, exNpc, dmemload;
    logic        valid, regWriteOut, memtoRegOut, haltOut, ren, wen, stall;
    logic [4:0]  wselOut;
    logic [31:0] aluout, ldata, npc, dmemaddr, dmemstore;

    int assertCount = 0;
    int failCount   = 0;

    exmem_latch dut (
        .CLK(clk), .nRST(nRst), .ihit(ihit), .dhit(dhit), .flush(flush),
        .ex_valid(exValid), .ex_RegWrite(exRegWrite), .ex_MemRead(exMemRead),
        .ex_MemWrite(exMemWrite), .ex_MemtoReg(exMemtoReg), .ex_halt(exHalt),
        .ex_wsel(exWsel), .ex_aluout(exAluout), .ex_storedata(exStoredata),
        .ex_npc(exNpc), .dmemload(dmemload),
        .exmem_valid(valid), .exmem_RegWrite_out(regWriteOut), .exmem_wsel_out(wselOut),
        .exmem_MemtoReg_out(memtoRegOut), .exmem_halt_out(haltOut),
        .exmem_aluout(aluout), .exmem_ldata(ldata), .exmem_npc(npc),
        .dmemREN(ren), .dmemWEN(wen), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .exmem_stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ihit, dhit, flush, exValid, regWrite, memRead, memWrite, memtoReg, halt;
        logic [4:0]  wsel;
        logic [31:0] aluout, storeData, npc, dmemload;
        logic        expValid, expRwo;
        logic [4:0]  expWsel;
        logic        expHalt;
        logic [31:0] expAlu, expLdata, expStore;
        logic        expRen, expWen, expStall;
    } vec_t;

    // Reference model: what sits in MEM and whether its memory request is still open.
    typedef struct {
        logic        valid, rw, mr, mw, m2r, halt;
        logic [4:0]  wsel;
        logic [31:0] alu, sd, npc;
    } mem_slot_t;

    mem_slot_t   mSlot;
    logic        mPending;
    logic [31:0] mLdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mSlot    = '{default: '0};
        mPending = 1'b0;
        mLdata   = '0;
    endtask

    task automatic modelClock();
        logic adv;
        adv = ihit && !mPending;
        if (mPending && dhit) begin
            if (mSlot.mr && !mSlot.mw) mLdata = dmemload;
            mPending = 1'b0;
        end
        if (adv) begin
            if (flush || !exValid) mSlot = '{default: '0};
            else mSlot = '{1'b1, exRegWrite, exMemRead, exMemWrite, exMemtoReg, exHalt,
                           exWsel, exAluout, exStoredata, exNpc};
            mPending = mSlot.valid && (mSlot.mr || mSlot.mw);
        end
    endtask

    task automatic checkOutput();
        logic rwo;
        rwo = mSlot.valid && mSlot.rw && (mSlot.wsel != 5'd0);
        check("valid",     32'(valid),       32'(mSlot.valid));
        check("regWrite",  32'(regWriteOut), 32'(rwo));
        check("wsel",      32'(wselOut),     rwo ? 32'(mSlot.wsel) : 32'd0);
        check("memtoReg",  32'(memtoRegOut), 32'(mSlot.m2r));
        check("halt",      32'(haltOut),     32'(mSlot.valid && mSlot.halt));
        check("aluout",    aluout,           mSlot.alu);
        check("dmemaddr",  dmemaddr,         mSlot.alu);
        check("dmemstore", dmemstore,        mSlot.sd);
        check("npc",       npc,              mSlot.npc);
        check("ldata",     ldata,            mLdata);
        check("REN",       32'(ren),         32'(mPending && mSlot.mr && !mSlot.mw));
        check("WEN",       32'(wen),         32'(mPending && mSlot.mw));
        check("stall",     32'(stall),       32'(mPending));
    endtask

    task automatic applyStimulus(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; flush = v.flush; exValid = v.exValid;
        exRegWrite = v.regWrite; exMemRead = v.memRead; exMemWrite = v.memWrite;
        exMemtoReg = v.memtoReg; exHalt = v.halt; exWsel = v.wsel;
        exAluout = v.aluout; exStoredata = v.storeData; exNpc = v.npc; dmemload = v.dmemload;
    endtask

    task automatic randomStimulus();
        ihit = ($urandom_range(0, 3) != 0);
        dhit = ($urandom_range(0, 2) == 0);
        flush = ($urandom_range(0, 9) == 0);
        exValid = ($urandom_range(0, 4) != 0);
        exRegWrite = $urandom_range(0, 1) == 1;
        exMemRead = ($urandom_range(0, 4) < 2);
        exMemWrite = ($urandom_range(0, 3) == 0);
        exMemtoReg = $urandom_range(0, 1) == 1;
        exHalt = ($urandom_range(0, 15) == 0);
        exWsel = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        exAluout = $urandom; exStoredata = $urandom; exNpc = $urandom; dmemload = $urandom;
    endtask

    // Full reset with inputs idle; the model is cleared alongside the DUT.
    task automatic doReset();
        vec_t z;
        z = '{default: '0};
        applyStimulus(z);
        nRst = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
    endtask

    vec_t table_q[$];

    initial begin
        vec_t sw;
        nRst = 1'b0;
        sw = '{default: '0};
        applyStimulus(sw);
        modelReset();
        @(negedge clk);
        checkOutput();
        nRst = 1'b1;

        //         ih dh fl ev rw mr mw m2 ht ws alu        sd      npc     dload         | v rwo ws  h alu       ldata         store  REN WEN stall
        table_q.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0, 5, 32'h10,   32'h0,  32'h4,  32'hBAD0,     1, 1, 5,  0, 32'h10,  32'h0,        32'h0,  0, 0, 0});
        table_q.push_back('{1, 0, 0, 1, 1, 1, 0, 1, 0, 8, 32'h40,   32'h7,  32'h8,  32'h0,        1, 1, 8,  0, 32'h40,  32'h0,        32'h7,  1, 0, 1});
        table_q.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 0, 3, 32'h99,   32'h0,  32'hC,  32'h0,        1, 1, 8,  0, 32'h40,  32'h0,        32'h7,  1, 0, 1});
        table_q.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 0, 3, 32'h99,   32'h0,  32'hC,  32'h0,        1, 1, 8,  0, 32'h40,  32'h0,        32'h7,  1, 0, 1});
        table_q.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0, 3, 32'h99,   32'h0,  32'hC,  32'hDEADBEEF, 1, 1, 8,  0, 32'h40,  32'hDEADBEEF, 32'h7,  0, 0, 0});
        table_q.push_back('{1, 0, 0, 1, 0, 1, 1, 0, 0, 6, 32'h80,   32'h55, 32'h10, 32'h0,        1, 0, 0,  0, 32'h80,  32'hDEADBEEF, 32'h55, 0, 1, 1});
        table_q.push_back('{1, 0, 1, 1, 1, 0, 0, 0, 0, 7, 32'h33,   32'h0,  32'h14, 32'h0,        1, 0, 0,  0, 32'h80,  32'hDEADBEEF, 32'h55, 0, 1, 1});
        table_q.push_back('{0, 1, 1, 1, 1, 0, 0, 0, 0, 7, 32'h33,   32'h0,  32'h14, 32'h12345678, 1, 0, 0,  0, 32'h80,  32'hDEADBEEF, 32'h55, 0, 0, 0});
        table_q.push_back('{1, 0, 1, 1, 1, 0, 0, 0, 0, 7, 32'h33,   32'h0,  32'h14, 32'h0,        0, 0, 0,  0, 32'h0,   32'hDEADBEEF, 32'h0,  0, 0, 0});
        table_q.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h20,   32'h0,  32'h18, 32'hBAD,      1, 0, 0,  0, 32'h20,  32'hDEADBEEF, 32'h0,  0, 0, 0});
        table_q.push_back('{1, 0, 0, 1, 1, 1, 0, 1, 0, 9, 32'h100,  32'h0,  32'h1C, 32'h0,        1, 1, 9,  0, 32'h100, 32'hDEADBEEF, 32'h0,  1, 0, 1});
        table_q.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0,  32'h0,  32'h11111111, 1, 1, 9,  0, 32'h100, 32'h11111111, 32'h0,  0, 0, 0});
        table_q.push_back('{1, 0, 0, 1, 1, 1, 0, 1, 0, 10, 32'h104, 32'h0,  32'h20, 32'h0,        1, 1, 10, 0, 32'h104, 32'h11111111, 32'h0,  1, 0, 1});
        table_q.push_back('{0, 1, 0, 1, 1, 1, 0, 1, 0, 10, 32'h104, 32'h0,  32'h20, 32'h22222222, 1, 1, 10, 0, 32'h104, 32'h22222222, 32'h0,  0, 0, 0});
        table_q.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 4, 32'h44,   32'h0,  32'h24, 32'h0,        1, 1, 10, 0, 32'h104, 32'h22222222, 32'h0,  0, 0, 0});
        table_q.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,    32'h0,  32'h28, 32'h0,        1, 0, 0,  1, 32'h0,   32'h22222222, 32'h0,  0, 0, 0});
        table_q.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 32'h9,    32'h0,  32'h2C, 32'h0,        1, 0, 0,  1, 32'h0,   32'h22222222, 32'h0,  0, 0, 0});

        foreach (table_q[i]) begin
            applyStimulus(table_q[i]);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d.valid", i),    32'(valid),       32'(table_q[i].expValid));
            check($sformatf("vec%0d.regWrite", i), 32'(regWriteOut), 32'(table_q[i].expRwo));
            check($sformatf("vec%0d.wsel", i),     32'(wselOut),     32'(table_q[i].expWsel));
            check($sformatf("vec%0d.halt", i),     32'(haltOut),     32'(table_q[i].expHalt));
            check($sformatf("vec%0d.aluout", i),   aluout,           table_q[i].expAlu);
            check($sformatf("vec%0d.dmemaddr", i), dmemaddr,         table_q[i].expAlu);
            check($sformatf("vec%0d.ldata", i),    ldata,            table_q[i].expLdata);
            check($sformatf("vec%0d.store", i),    dmemstore,        table_q[i].expStore);
            check($sformatf("vec%0d.REN", i),      32'(ren),         32'(table_q[i].expRen));
            check($sformatf("vec%0d.WEN", i),      32'(wen),         32'(table_q[i].expWen));
            check($sformatf("vec%0d.stall", i),    32'(stall),       32'(table_q[i].expStall));
        end

        // Asynchronous reset while a store is waiting on memory.
        doReset();
        sw = '{default: '0};
        sw.ihit = 1; sw.exValid = 1; sw.memWrite = 1; sw.aluout = 32'h200; sw.storeData = 32'hA5;
        applyStimulus(sw);
        @(posedge clk);
        @(negedge clk);
        check("rstSeq.WENbefore", 32'(wen), 32'd1);
        check("rstSeq.stallBefore", 32'(stall), 32'd1);
        #2 nRst = 1'b0;
        #1;
        check("rstSeq.WEN", 32'(wen), 32'd0);
        check("rstSeq.stall", 32'(stall), 32'd0);
        check("rstSeq.valid", 32'(valid), 32'd0);
        check("rstSeq.dmemaddr", dmemaddr, 32'd0);
        @(negedge clk);
        sw.ihit = 0;
        applyStimulus(sw);
        nRst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstSeq.idleAfter", 32'(stall), 32'd0);

        // Random traffic against the reference model.
        doReset();
        for (int c = 0; c < 400; c++) begin
            randomStimulus();
            @(posedge clk);
            modelClock();
            @(negedge clk);
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
